// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use and ecall hazard detection and a RUN/HALTED FSM.
// Optional `STALL_COUNT_EN adds a 32-bit stall_cycles counter output.
module id_ex_ctrl_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [16:0] id_ctrl,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_x17_eq_10,
  input  logic        ex_flush,
  output logic [16:0] ex_ctrl,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall,
  output logic        halted
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [4:0] REG_A7 = 5'd17;

  typedef enum logic {RUN, HALTED} state_t;

  state_t     state;
  logic [4:0] mem_rd;
  logic       mem_we;
  logic       mem_valid;

  logic ex_mem_read;
  logic ex_write_enable;
  logic id_is_ecall;
  logic rs1_match;
  logic rs2_match;
  logic load_use;
  logic a7_pending_ex;
  logic a7_pending_mem;
  logic ecall_hazard;
  logic issue;
  logic halt_now;

  assign ex_mem_read     = ex_ctrl[9];
  assign ex_write_enable = ex_ctrl[5];
  assign id_is_ecall     = id_ctrl[3];

  // x0 is hardwired, so a load targeting it can never feed a dependent instruction.
  always_comb begin
    rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    load_use  = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);
  end

  // ecall reads a7 straight from the register file, so it must wait until
  // any in-flight write to x17 has cleared both EX and MEM.
  always_comb begin
    a7_pending_ex  = ex_valid && ex_write_enable && (ex_rd == REG_A7);
    a7_pending_mem = mem_valid && mem_we && (mem_rd == REG_A7);
    ecall_hazard   = id_valid && id_is_ecall && (a7_pending_ex || a7_pending_mem);
  end

  always_comb begin
    stall = 1'b0;
    if (state == HALTED) begin
      stall = 1'b1;
    end else begin
      stall = (load_use || ecall_hazard) && !ex_flush;
    end
  end

  always_comb begin
    issue    = (state == RUN) && !ex_flush && !stall && id_valid;
    halt_now = issue && id_is_ecall && id_x17_eq_10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      halted    <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      ex_valid  <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      mem_rd    <= ex_rd;
      mem_we    <= ex_write_enable;
      mem_valid <= ex_valid;
      case (state)
        RUN: begin
          if (issue) begin
            ex_ctrl  <= id_ctrl;
            ex_rd    <= id_rd;
            ex_valid <= 1'b1;
          end else begin
            ex_ctrl  <= '0;
            ex_rd    <= '0;
            ex_valid <= 1'b0;
          end
          if (halt_now) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          ex_ctrl  <= '0;
          ex_rd    <= '0;
          ex_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= RUN;
          halted   <= 1'b0;
          ex_ctrl  <= '0;
          ex_rd    <= '0;
          ex_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if ((state == RUN) && stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_ctrl_stage.md
ID_EX_CTRL_STAGE -- requirements
Module: id_ex_ctrl_stage

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-003 SHALL have: id_valid  in  1  ID holds a real (non-bubble) instruction.
REQ-004 SHALL have: id_ctrl  in  17  decoded controls: [16:10] alu_op, [9] mem_read, [8] mem_to_reg, [7] mem_write, [6] alu_src, [5] write_enable, [4] pc_to_reg, [3] is_ecall, [2] is_jal, [1] is_jalr, [0] branch.
REQ-005 SHALL have: id_rs1, id_rs2, id_rd  in  5 each  ID register indices.
REQ-006 SHALL have: id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2.
REQ-007 SHALL have: id_x17_eq_10  in  1  register-file x17 read equals 10.
REQ-008 SHALL have: ex_flush  in  1  control-flow redirect resolved in EX; ID instruction is wrong-path.
REQ-009 SHALL have: ex_ctrl  out  17  registered controls to EX, same packing as id_ctrl.
REQ-010 SHALL have: ex_rd  out  5; ex_valid  out  1  registered EX destination and validity.
REQ-011 SHALL have: stall  out  1  combinational; holds PC and IF/ID when 1.
REQ-012 SHALL have: halted  out  1  registered; program terminated.

Function
REQ-013 SHALL track an internal MEM shadow (mem_rd, mem_we, mem_valid) loaded each cycle from ex_rd, ex_ctrl[5], ex_valid.
REQ-014 Load-use hazard SHALL be: ex_valid & ex_ctrl[9] & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), id_valid=1.
REQ-015 Ecall hazard SHALL be: id_valid & id_ctrl[3] & ((ex_valid & ex_ctrl[5] & ex_rd==17) | (mem_valid & mem_we & mem_rd==17)); up to 2 stall cycles.
REQ-016 stall SHALL = (load-use | ecall hazard) & ~ex_flush & state==RUN, or 1 in HALTED.
REQ-017 Bubble SHALL mean ex_ctrl=0, ex_rd=0, ex_valid=0 on next edge.
REQ-018 Per edge in RUN, priority: ex_flush -> bubble; else stall -> bubble; else issue (ex_ctrl<=id_ctrl, ex_rd<=id_rd, ex_valid<=id_valid); id_valid=0 -> bubble.
REQ-019 FSM states RUN, HALTED; RUN->HALTED when an ecall issues (REQ-018 issue path, id_ctrl[3]=1) with id_x17_eq_10=1; halted asserts same edge.
REQ-020 HALTED SHALL be absorbing until reset; ex_flush ignored; only bubbles enter EX; the halting ecall itself is issued once.
REQ-021 Latency: ID->EX one cycle; hazards never change ex_* within the same cycle.
REQ-022 Register index 0 SHALL never create a hazard.

Reset
REQ-023 On reset low: ex_ctrl=0, ex_rd=0, ex_valid=0, mem shadow=0, state=RUN, halted=0, counter=0; mid-operation reset discards in-flight stalls.
REQ-024 First edge after reset release SHALL process inputs normally.

Configuration
REQ-025 Macro STALL_COUNT_EN defined: add output stall_cycles (32-bit) incrementing each cycle stall=1 in RUN, wrapping 0xFFFFFFFF->0, frozen in HALTED.
REQ-026 Macro undefined: no stall_cycles port or counter; all other behaviour identical.

Verification
REQ-027 Load x5 in EX (ex_ctrl[9]=1, ex_rd=5), ID add uses rs1=5 -> stall=1 one cycle, bubble, then add issues.
REQ-028 ID ecall, EX writes x17 -> stall 2 cycles (EX then MEM shadow), ecall issues on third edge.
REQ-029 Load-use hazard plus ex_flush same cycle -> stall=0, bubble issued.
REQ-030 Ecall issued with id_x17_eq_10=1 -> halted=1 next edge, stall=1 thereafter, ex_valid=0 forever, flush ignored.
REQ-031 Load with ex_rd=0, ID uses rs1=0 -> no stall.
REQ-032 Reset low during 2-cycle ecall stall -> all outputs 0 immediately, stall=0 after release with id_valid=0.
